// File: rtl/dda_ray_tx_if.sv
// Ray stream bundle between the DDA core, the ray TX FIFO and the transformation stage.
// The DUT uses the slave modport; a bench or upstream wrapper drives it through master.
interface dda_ray_tx_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ray_valid_in;
    logic          ray_ready_out;
    logic [8:0]    hcount_in;
    logic [15:0]   line_height_in;
    logic          wall_type_in;
    logic [3:0]    map_data_in;
    logic [15:0]   wall_x_in;
    logic          dda_fifo_tvalid_out;
    logic [37:0]   dda_fifo_tdata_out;
    logic          dda_fifo_tlast_out;
    logic          dda_fifo_tready_in;
    logic          frame_done_out;
    logic          order_err_out;
    logic [CW-1:0] fill_count_out;

    modport slave (
        input  ray_valid_in, hcount_in, line_height_in, wall_type_in, map_data_in, wall_x_in,
        input  dda_fifo_tready_in,
        output ray_ready_out, dda_fifo_tvalid_out, dda_fifo_tdata_out, dda_fifo_tlast_out,
        output frame_done_out, order_err_out, fill_count_out
    );

    modport master (
        output ray_valid_in, hcount_in, line_height_in, wall_type_in, map_data_in, wall_x_in,
        output dda_fifo_tready_in,
        input  ray_ready_out, dda_fifo_tvalid_out, dda_fifo_tdata_out, dda_fifo_tlast_out,
        input  frame_done_out, order_err_out, fill_count_out
    );
endinterface

// File: rtl/dda_ray_tx.sv
// Transmit side of the DDA ray stream: clamps and packs each column result, queues it in a
// small FIFO and presents it on a valid/data/last stream, tracking column order and frame end.
module dda_ray_tx #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int DEPTH         = 8
) (
    input logic          pixel_clk_in,
    input logic          rst_in,
    dda_ray_tx_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0]    LAST_COL   = 9'(SCREEN_WIDTH - 1);
    localparam logic [15:0]   HEIGHT_MAX = 16'(SCREEN_HEIGHT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Each entry carries its tlast flag in bit 38 above the 38-bit column word.
    logic [38:0]   mem_q [DEPTH];
    logic [38:0]   mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    expected_q, expected_d;
    logic          order_err_q, order_err_d;
    logic          frame_done_q, frame_done_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    height;
    logic [38:0]   in_word;
    logic [38:0]   head_word;

    always_comb begin
        full      = (count_q == FULL_COUNT);
        empty     = (count_q == '0);
        push      = bus.ray_valid_in && !full;
        pop       = !empty && bus.dda_fifo_tready_in;
        height    = (bus.line_height_in > HEIGHT_MAX) ? HEIGHT_MAX[7:0] : bus.line_height_in[7:0];
        in_word   = {(bus.hcount_in == LAST_COL), bus.hcount_in, height,
                     bus.wall_type_in, bus.map_data_in, bus.wall_x_in};
        head_word = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        expected_d   = expected_q;
        order_err_d  = order_err_q;
        frame_done_d = pop && head_word[38];

        if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Out-of-range columns can never be in sequence, so they always flag an error.
        if (push) begin
            if ((bus.hcount_in != expected_q) || (bus.hcount_in > LAST_COL)) begin
                order_err_d = 1'b1;
            end
            expected_d = (bus.hcount_in == LAST_COL) ? 9'd0 : bus.hcount_in + 9'd1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            expected_q   <= '0;
            order_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            expected_q   <= expected_d;
            order_err_q  <= order_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge pixel_clk_in) begin
        mem_q <= mem_d;
    end

    assign bus.ray_ready_out       = !full;
    assign bus.dda_fifo_tvalid_out = !empty;
    assign bus.dda_fifo_tdata_out  = empty ? 38'd0 : head_word[37:0];
    assign bus.dda_fifo_tlast_out  = !empty && head_word[38];
    assign bus.frame_done_out      = frame_done_q;
    assign bus.order_err_out       = order_err_q;
    assign bus.fill_count_out      = count_q;
endmodule

// File: tb/tb_dda_ray_tx.sv
// Directed bench for dda_ray_tx: a queue-based reference model checked every cycle,
// plus literal expectations at the points the column-stream rules single out.
module tb_dda_ray_tx;
    localparam int W     = 320;
    localparam int H     = 180;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dda_ray_tx_if #(.DEPTH(DEPTH)) bus();

    dda_ray_tx #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .DEPTH         (DEPTH)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int fd_pulses   = 0;
    bit checking    = 0;

    logic [38:0] mq[$];
    int          m_exp;
    bit          m_err;
    bit          m_fd;
    bit          do_pop;
    bit          do_push;
    int          h_in;
    logic [38:0] new_word;

    function automatic logic [38:0] pack_word(input int h, input int lh, input bit wt,
                                              input int md, input int wx);
        int ht;
        ht = (lh > H) ? H : lh;
        return {(h == W - 1), 9'(h), 8'(ht), wt, 4'(md), 16'(wx)};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, order tracking as a plain expected column number.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_exp    = 0;
            m_err    = 0;
            m_fd     = 0;
            checking = 1;
        end else begin
            do_pop  = (mq.size() > 0) && (bus.dda_fifo_tready_in === 1'b1);
            do_push = (bus.ray_valid_in === 1'b1) && (mq.size() < DEPTH);
            m_fd    = 0;
            if (do_pop) m_fd = mq[0][38];
            if (do_push) begin
                h_in     = int'(bus.hcount_in);
                new_word = pack_word(h_in, int'(bus.line_height_in), bus.wall_type_in,
                                     int'(bus.map_data_in), int'(bus.wall_x_in));
                if (h_in != m_exp || h_in >= W) m_err = 1;
                m_exp = (h_in == W - 1) ? 0 : h_in + 1;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(new_word);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("tvalid", bus.dda_fifo_tvalid_out, mq.size() != 0);
            check_output("ray_ready", bus.ray_ready_out, mq.size() < DEPTH);
            check_output("fill_count", bus.fill_count_out, mq.size());
            check_output("order_err", bus.order_err_out, m_err);
            check_output("frame_done", bus.frame_done_out, m_fd);
            if (mq.size() != 0) begin
                check_output("tdata", bus.dda_fifo_tdata_out, mq[0][37:0]);
                check_output("tlast", bus.dda_fifo_tlast_out, mq[0][38]);
            end else begin
                check_output("tdata_idle", bus.dda_fifo_tdata_out, 0);
                check_output("tlast_idle", bus.dda_fifo_tlast_out, 0);
            end
            if (bus.frame_done_out === 1'b1) fd_pulses++;
        end
    end

    // Drives one result for one cycle; callers are always aligned to a falling edge.
    task automatic apply_stimulus(input int h, input int lh, input bit wt, input int md, input int wx);
        bus.ray_valid_in   = 1'b1;
        bus.hcount_in      = 9'(h);
        bus.line_height_in = 16'(lh);
        bus.wall_type_in   = wt;
        bus.map_data_in    = 4'(md);
        bus.wall_x_in      = 16'(wx);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.ray_valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.ray_valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.ray_valid_in       = 1'b0;
        bus.hcount_in          = '0;
        bus.line_height_in     = '0;
        bus.wall_type_in       = 1'b0;
        bus.map_data_in        = '0;
        bus.wall_x_in          = '0;
        bus.dda_fifo_tready_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_output("reset_tvalid", bus.dda_fifo_tvalid_out, 0);
        check_output("reset_fill", bus.fill_count_out, 0);

        // Full frame streamed straight through.
        bus.dda_fifo_tready_in = 1'b1;
        for (int h = 0; h < W; h++) begin
            apply_stimulus(h, (h * 7) % 300, h[0], h % 16, (h * 97) & 16'hffff);
        end
        idle(4);
        check_output("t1_frame_done_pulses", fd_pulses, 1);
        check_output("t1_order_err", bus.order_err_out, 0);

        // Back-pressure: only DEPTH of ten words get in.
        bus.dda_fifo_tready_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i, 50 + i, 1'b0, i, i);
        end
        bus.ray_valid_in = 1'b0;
        check_output("t2_fill_full", bus.fill_count_out, 8);
        check_output("t2_ready_low", bus.ray_ready_out, 0);
        check_output("t2_head_hcount", bus.dda_fifo_tdata_out[37:29], 0);
        bus.dda_fifo_tready_in = 1'b1;
        idle(10);
        check_output("t2_drained", bus.fill_count_out, 0);

        // Height clamping on 400, 180, 0.
        bus.dda_fifo_tready_in = 1'b0;
        apply_stimulus(8, 400, 1'b1, 3, 16'h1234);
        apply_stimulus(9, 180, 1'b0, 5, 16'h8000);
        apply_stimulus(10, 0, 1'b1, 15, 16'hffff);
        idle(1);
        check_output("t3_height_400", bus.dda_fifo_tdata_out[28:21], 180);
        bus.dda_fifo_tready_in = 1'b1;
        @(negedge clk);
        check_output("t3_height_180", bus.dda_fifo_tdata_out[28:21], 180);
        @(negedge clk);
        check_output("t3_height_0", bus.dda_fifo_tdata_out[28:21], 0);
        idle(2);

        // Column skip 0,1,3,4.
        do_reset();
        apply_stimulus(0, 20, 1'b0, 1, 1);
        apply_stimulus(1, 20, 1'b0, 1, 1);
        check_output("t4_no_err", bus.order_err_out, 0);
        apply_stimulus(3, 20, 1'b0, 1, 1);
        check_output("t4_err_on_3", bus.order_err_out, 1);
        apply_stimulus(4, 20, 1'b0, 1, 1);
        check_output("t4_err_sticky", bus.order_err_out, 1);
        idle(3);

        // Push and pop every cycle around a single entry.
        do_reset();
        for (int h = 0; h < 20; h++) begin
            apply_stimulus(h, h * 11, h[1], h, h * 3);
            check_output("t5_tvalid", bus.dda_fifo_tvalid_out, 1);
            check_output("t5_fill_one", bus.fill_count_out, 1);
        end
        idle(3);

        // Column index beyond the screen.
        do_reset();
        bus.dda_fifo_tready_in = 1'b0;
        apply_stimulus(400, 10, 1'b0, 2, 2);
        idle(1);
        check_output("t7_err_oob", bus.order_err_out, 1);
        check_output("t7_tlast_oob", bus.dda_fifo_tlast_out, 0);
        check_output("t7_hcount_oob", bus.dda_fifo_tdata_out[37:29], 400);
        bus.dda_fifo_tready_in = 1'b1;
        idle(3);

        // Reset with words stuck in the FIFO.
        do_reset();
        bus.dda_fifo_tready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(i, 30, 1'b0, i, i);
        end
        idle(1);
        check_output("t6_fill_five", bus.fill_count_out, 5);
        do_reset();
        check_output("t6_tvalid_after_rst", bus.dda_fifo_tvalid_out, 0);
        check_output("t6_fill_after_rst", bus.fill_count_out, 0);
        apply_stimulus(0, 30, 1'b0, 0, 0);
        idle(1);
        check_output("t6_no_err", bus.order_err_out, 0);
        check_output("t6_fill_one", bus.fill_count_out, 1);
        bus.dda_fifo_tready_in = 1'b1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
